ones_pattern_generator: RTL and testbench
=========================================

// Module: ones_pattern_generator
// PURPOSE
//  Inverse of the ones counter: accepts a ones-count and builds an
//  INPUT_FEATURES-wide thermometer pattern containing exactly that many HIGH bits.
//  Sets one bit per clock cycle, then holds the pattern under a valid/ready handshake.
//  Used to regenerate feature vectors from counts for stimulus and self-check
//  paths. The ones count of pattern_o always equals the accepted (clamped) count.
// PARAMETERS
//  INPUT_FEATURES  8  width of the generated pattern; >= 1
//  MSB_FIRST       0  0: fill from bit 0 upward; 1: fill from bit INPUT_FEATURES-1 downward
//  (derived) CW = $clog2(INPUT_FEATURES+1), the width of the count
// PORTS
//  clock_i          in   1      clock; all state changes on the rising edge
//  reset_i          in   1      reset, asynchronous, active-high
//  count_i          in   CW     requested number of ones
//  count_valid_i    in   1      count_i is valid
//  count_ready_o    out  1      block accepts a count (IDLE only)
//  pattern_o        out  N      generated pattern (N = INPUT_FEATURES)
//  pattern_valid_o  out  1      pattern_o complete and stable
//  pattern_ready_i  in   1      consumer accepts pattern_o
//  saturated_o      out  1      count_i exceeded N and was clamped
//  busy_o           out  1      state != IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE, pattern_o=0, pattern_valid_o=0, saturated_o=0, busy_o=0.
//   count_ready_o=0 while reset_i=1. It is 1 in the first cycle after release.
//  FSM states IDLE, FILL, HOLD. count_ready_o = (state==IDLE) && !reset_i.
//  IDLE: accept on count_valid_i && count_ready_o. At the accepting edge:
//   target = min(count_i, N); saturated_o = (count_i > N); pattern_o = 0; idx = 0.
//   Next state is HOLD if target == 0, otherwise FILL.
//  FILL: each edge sets bit idx (MSB_FIRST=0) or bit N-1-idx (MSB_FIRST=1), then idx++.
//   Goes to HOLD on the edge that sets the target-th bit.
//   Partial patterns are visible on pattern_o with pattern_valid_o=0.
//  HOLD: pattern_valid_o=1; pattern_o and saturated_o are stable.
//   On pattern_ready_i=1 the next state is IDLE, with pattern_o=0, saturated_o=0,
//   and pattern_valid_o=0 from the following cycle.
//  Latency: with the accept in cycle A, pattern_valid_o first goes high in cycle
//   A+target+1 (count 0 -> A+1; count N -> A+N+1).
//  No overlap: one transaction in flight. The next count is accepted no earlier
//   than the cycle after the pattern handshake.
//  count_valid_i outside IDLE is ignored (not consumed).
//   pattern_ready_i outside HOLD is ignored.
//  idx width is CW and never exceeds N; no wrap-around is possible.
//  Reset mid-FILL or mid-HOLD aborts the transaction: the pattern is lost, no
//   pattern_valid_o is emitted, and the block returns to IDLE.
//  Invariant in HOLD: popcount(pattern_o) == target, set bits are contiguous from
//   the fill end, and the other bits are 0.
// TESTING
//  1 Reset pulse mid-cycle -> all outputs 0 immediately; count_ready_o=1 the
//    cycle after release.
//  2 N=8, MSB_FIRST=0, count=3 -> pattern_o 8'h01, 8'h03, 8'h07; pattern_valid_o
//    at A+4; saturated_o=0.
//  3 count=0 -> pattern_o=8'h00, pattern_valid_o at A+1; count=8 ->
//    pattern_o=8'hFF at A+9.
//  4 count=12 (CW=4) -> pattern_o=8'hFF at A+9, saturated_o=1; cleared after
//    the pattern handshake.
//  5 Hold pattern_ready_i=0 for 5 cycles with count_valid_i=1 -> pattern_o
//    stable, count_ready_o=0; after ready=1, the next count is accepted in IDLE.
//  6 count=6, assert reset_i after 3 FILL cycles -> pattern_o=0, IDLE, no valid;
//    MSB_FIRST=1 count=2 -> 8'hC0.
//  Self-check: feed pattern_o into the ones counter; its result must equal the
//  clamped count.

Source files
------------

// File: rtl/ones_pattern_generator.sv
// Count-to-thermometer pattern generator: accepts a ones-count, sets one bit per
// clock until the pattern holds exactly that many ones, then offers it under valid/ready.
module ones_pattern_generator #(
  parameter int INPUT_FEATURES = 8,
  parameter bit MSB_FIRST      = 1'b0,
  localparam int CW            = $clog2(INPUT_FEATURES + 1)
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic [CW-1:0]             count_i,
  input  logic                      count_valid_i,
  output logic                      count_ready_o,
  output logic [INPUT_FEATURES-1:0] pattern_o,
  output logic                      pattern_valid_o,
  input  logic                      pattern_ready_i,
  output logic                      saturated_o,
  output logic                      busy_o
);

  localparam logic [CW-1:0] N_CW = CW'(INPUT_FEATURES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                      state_reg, state_next;
  logic [CW-1:0]               target_reg, target_next;
  logic [CW-1:0]               idx_reg, idx_next;
  logic [INPUT_FEATURES-1:0]   pattern_reg, pattern_next;
  logic                        saturated_reg, saturated_next;

  logic                        accept;
  logic                        count_over;
  logic [CW-1:0]               count_clamped;
  logic [CW-1:0]               idx_inc;
  logic                        last_bit;
  logic [INPUT_FEATURES-1:0]   fill_mask;

  assign accept        = (state_reg == IDLE) && count_valid_i;
  assign count_over    = (count_i > N_CW);
  assign count_clamped = count_over ? N_CW : count_i;
  assign idx_inc       = idx_reg + CW'(1);
  assign last_bit      = (idx_inc == target_reg);

  // One-hot mask of the bit written this FILL cycle; MSB_FIRST mirrors the position.
  genvar gi;
  generate
    for (gi = 0; gi < INPUT_FEATURES; gi++) begin : g_mask
      localparam int POS = MSB_FIRST ? (INPUT_FEATURES - 1 - gi) : gi;
      assign fill_mask[POS] = (idx_reg == CW'(gi));
    end
  endgenerate

  // State register, asynchronous reset
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg     <= IDLE;
      target_reg    <= '0;
      idx_reg       <= '0;
      pattern_reg   <= '0;
      saturated_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      target_reg    <= target_next;
      idx_reg       <= idx_next;
      pattern_reg   <= pattern_next;
      saturated_reg <= saturated_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: if (accept) state_next = (count_clamped == '0) ? HOLD : FILL;
      FILL: if (last_bit) state_next = HOLD;
      HOLD: if (pattern_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath updates
  always_comb begin
    target_next    = target_reg;
    idx_next       = idx_reg;
    pattern_next   = pattern_reg;
    saturated_next = saturated_reg;
    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          target_next    = count_clamped;
          saturated_next = count_over;
          pattern_next   = '0;
          idx_next       = '0;
        end
      end
      FILL: begin
        pattern_next = pattern_reg | fill_mask;
        idx_next     = idx_inc;
      end
      HOLD: begin
        if (pattern_ready_i) begin
          pattern_next   = '0;
          saturated_next = 1'b0;
        end
      end
      default: begin
        pattern_next   = '0;
        saturated_next = 1'b0;
      end
    endcase
  end

  // Outputs; count_ready_o drops combinationally while reset is held
  always_comb begin
    count_ready_o   = (state_reg == IDLE) && !reset_i;
    pattern_valid_o = (state_reg == HOLD);
    busy_o          = (state_reg != IDLE);
    pattern_o       = pattern_reg;
    saturated_o     = saturated_reg;
  end

endmodule

// File: tb/tb_ones_pattern_generator.sv
// Bench for ones_pattern_generator: LSB-first and MSB-first instances share stimulus;
// a vector table plus hand-written reset and back-pressure sequences.
module tb_ones_pattern_generator;

  localparam int N        = 8;
  localparam int CW       = 4;
  localparam int MAX_WAIT = 40;

  logic          clk;
  logic          reset_i;
  logic [CW-1:0] count_i;
  logic          count_valid_i;
  logic          pattern_ready_i;

  logic          cr0, pv0, sat0, busy0;
  logic [N-1:0]  pat0;
  logic          cr1, pv1, sat1, busy1;
  logic [N-1:0]  pat1;

  int checks = 0;
  int errors = 0;

  ones_pattern_generator #(.INPUT_FEATURES(N), .MSB_FIRST(1'b0)) dut_lsb (
    .clock_i(clk), .reset_i(reset_i), .count_i(count_i), .count_valid_i(count_valid_i),
    .count_ready_o(cr0), .pattern_o(pat0), .pattern_valid_o(pv0),
    .pattern_ready_i(pattern_ready_i), .saturated_o(sat0), .busy_o(busy0)
  );

  ones_pattern_generator #(.INPUT_FEATURES(N), .MSB_FIRST(1'b1)) dut_msb (
    .clock_i(clk), .reset_i(reset_i), .count_i(count_i), .count_valid_i(count_valid_i),
    .count_ready_o(cr1), .pattern_o(pat1), .pattern_valid_o(pv1),
    .pattern_ready_i(pattern_ready_i), .saturated_o(sat1), .busy_o(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         count;
    int         hold;
    logic [7:0] lsb;
    logic [7:0] msb;
    logic       sat;
    int         lat;
  } vec_t;

  typedef struct {
    int         clamp;
    logic [7:0] lsb;
    logic [7:0] msb;
    logic       sat;
    int         lat;
  } exp_t;

  vec_t vecs[9];
  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] therm_lsb(input int n);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (i < n) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [7:0] therm_msb(input int n);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (i < n) r[7-i] = 1'b1;
    return r;
  endfunction

  function automatic exp_t make_exp(input int count, input logic [7:0] lsb,
                                    input logic [7:0] msb, input logic sat, input int lat);
    exp_t e;
    e.clamp = (count > N) ? N : count;
    e.lsb   = lsb;
    e.msb   = msb;
    e.sat   = sat;
    e.lat   = lat;
    return e;
  endfunction

  // Waits for count_ready, presents the count, pushes the expectation; returns just after the accepting edge.
  task automatic start_txn(input int count, input logic [7:0] lsb, input logic [7:0] msb,
                           input logic sat, input int lat);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < MAX_WAIT; k++) begin
      @(negedge clk);
      if (cr0 && cr1) begin
        ok = 1'b1;
        break;
      end
    end
    check("count_ready_wait", {31'd0, ok}, 32'd1);
    count_i       = CW'(count);
    count_valid_i = 1'b1;
    sb_q.push_back(make_exp(count, lsb, msb, sat, lat));
    @(posedge clk);
    #1;
    count_valid_i = 1'b0;
  endtask

  // Follows the fill, compares the held pattern to the scoreboard, stalls, then handshakes.
  task automatic finish_txn(input int hold, input bit keep_valid);
    exp_t       e;
    bit         seen;
    int         lat;
    logic [7:0] held;
    seen = 1'b0;
    lat  = 0;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    for (int k = 1; k <= MAX_WAIT; k++) begin
      @(negedge clk);
      if (pv0) begin
        seen = 1'b1;
        lat  = k;
        break;
      end
      check("partial_lsb", {24'd0, pat0}, {24'd0, therm_lsb(k - 1)});
      check("partial_msb", {24'd0, pat1}, {24'd0, therm_msb(k - 1)});
      check("busy_fill", {31'd0, busy0}, 32'd1);
    end
    check("valid_seen", {31'd0, seen}, 32'd1);
    if (!seen) return;
    $display("txn clamp=%0d lat=%0d pat_lsb=%02h pat_msb=%02h sat=%0b",
             e.clamp, lat, pat0, pat1, sat0);
    check("latency", lat, e.lat);
    check("valid_msb", {31'd0, pv1}, 32'd1);
    check("pattern_lsb", {24'd0, pat0}, {24'd0, e.lsb});
    check("pattern_msb", {24'd0, pat1}, {24'd0, e.msb});
    check("saturated_lsb", {31'd0, sat0}, {31'd0, e.sat});
    check("saturated_msb", {31'd0, sat1}, {31'd0, e.sat});
    check("popcount", $countones(pat0), e.clamp);
    check("ready_in_hold", {31'd0, cr0}, 32'd0);
    held = pat0;
    for (int h = 0; h < hold; h++) begin
      if (keep_valid) begin
        count_i       = CW'(5);
        count_valid_i = 1'b1;
      end
      @(negedge clk);
      check("hold_valid", {31'd0, pv0}, 32'd1);
      check("hold_stable", {24'd0, pat0}, {24'd0, held});
      check("hold_ready", {31'd0, cr0 | cr1}, 32'd0);
    end
    pattern_ready_i = 1'b1;
    @(posedge clk);
    #1;
    pattern_ready_i = 1'b0;
    @(negedge clk);
    check("post_valid", {31'd0, pv0 | pv1}, 32'd0);
    check("post_pattern", {16'd0, pat0, pat1}, 32'd0);
    check("post_sat", {31'd0, sat0 | sat1}, 32'd0);
    check("post_busy", {31'd0, busy0 | busy1}, 32'd0);
    check("post_ready", {31'd0, cr0 & cr1}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{3,  0, 8'h07, 8'hE0, 1'b0, 4};
    vecs[1] = '{0,  1, 8'h00, 8'h00, 1'b0, 1};
    vecs[2] = '{8,  2, 8'hFF, 8'hFF, 1'b0, 9};
    vecs[3] = '{12, 0, 8'hFF, 8'hFF, 1'b1, 9};
    vecs[4] = '{1,  0, 8'h01, 8'h80, 1'b0, 2};
    vecs[5] = '{2,  3, 8'h03, 8'hC0, 1'b0, 3};
    vecs[6] = '{5,  0, 8'h1F, 8'hF8, 1'b0, 6};
    vecs[7] = '{9,  1, 8'hFF, 8'hFF, 1'b1, 9};
    vecs[8] = '{15, 0, 8'hFF, 8'hFF, 1'b1, 9};

    reset_i         = 1'b1;
    count_i         = '0;
    count_valid_i   = 1'b0;
    pattern_ready_i = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outputs", {15'd0, pat0, pv0, sat0, busy0, cr0, pat1}, 32'd0);
    reset_i = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {31'd0, cr0 & cr1}, 32'd1);
    check("idle_busy", {31'd0, busy0 | busy1}, 32'd0);

    foreach (vecs[i]) begin
      start_txn(vecs[i].count, vecs[i].lsb, vecs[i].msb, vecs[i].sat, vecs[i].lat);
      finish_txn(vecs[i].hold, 1'b0);
    end

    // Back-pressure with a pending count: held in HOLD, accepted only after the handshake
    start_txn(2, 8'h03, 8'hC0, 1'b0, 3);
    finish_txn(5, 1'b1);
    sb_q.push_back(make_exp(5, 8'h1F, 8'hF8, 1'b0, 6));
    @(posedge clk);
    #1;
    count_valid_i = 1'b0;
    check("accept_after_hold", {31'd0, busy0 & busy1}, 32'd1);
    finish_txn(0, 1'b0);

    // Asynchronous reset in the middle of a fill
    start_txn(6, 8'h3F, 8'hFC, 1'b0, 7);
    repeat (3) @(negedge clk);
    check("mid_fill_lsb", {24'd0, pat0}, 32'h03);
    check("mid_fill_msb", {24'd0, pat1}, 32'hC0);
    #1;
    reset_i = 1'b1;
    #1;
    check("abort_pattern", {16'd0, pat0, pat1}, 32'd0);
    check("abort_flags", {27'd0, pv0, busy0, cr0, pv1, busy1}, 32'd0);
    sb_q.delete();
    @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    check("abort_ready", {31'd0, cr0 & cr1}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("abort_no_valid", {30'd0, pv0, pv1}, 32'd0);
    end

    // Recovery after the abort
    start_txn(2, 8'h03, 8'hC0, 1'b0, 3);
    finish_txn(1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
